// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore instruction sequencer for the 16-bit register/ALU datapath.
// Holds one instruction in IR, decodes it and steps the datapath through
// register read, ALU and write-back. s/w start/ready handshake upstream.
// Optional retired-instruction counter: define DATAPATH_CTRL_PERF_CNT_EN.
module datapath_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic             load,
  input  logic [15:0]      in,
  output logic             w,
  output logic             err,
  output logic [3:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic [15:0]      sximm8,
  output logic [15:0]      sximm5,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_t;

  state_t      state;
  logic [15:0] ir;

  // IR field split
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  logic is_movi, is_mov, is_alu, is_mvn, is_cmp;
  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov  = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_cmp  = is_alu && (op == 2'b01);

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // Sequencer: state, IR capture and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (load) ir <= in;
          if (s) begin
            state <= S_DECODE;
            err   <= 1'b0;
          end
        end
        S_DECODE: begin
          if (is_movi)               state <= S_WRITE_IMM;
          else if (is_mov || is_mvn) state <= S_GET_B;
          else if (is_alu)           state <= S_GET_A;
          else begin
            err   <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WRITE_IMM: state <= S_WAIT;
        S_GET_A:     state <= S_GET_B;
        S_GET_B:     state <= S_ALU;
        S_ALU:       state <= is_cmp ? S_WAIT : S_WRITE_REG;
        S_WRITE_REG: state <= S_WAIT;
        default:     state <= S_WAIT;
      endcase
    end
  end

`ifdef DATAPATH_CTRL_PERF_CNT_EN
  logic retire;
  assign retire = (state == S_WRITE_IMM) || (state == S_WRITE_REG) ||
                  ((state == S_ALU) && is_cmp);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!reset_n)    instr_count <= '0;
    else if (retire) instr_count <= instr_count + 1'b1;
  end
`else
  assign instr_count = '0;
`endif

  // Moore output decode from state and IR only
  always_comb begin
    w        = (state == S_WAIT);
    vsel     = 4'b0001;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    case (state)
      S_WRITE_IMM: begin
        vsel     = 4'b0100;
        writenum = rn;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        asel  = is_mov || is_mvn;
        ALUop = is_mov ? 2'b00 : (is_mvn ? 2'b11 : op);
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
Instruction-sequencing controller for the 16-bit register/ALU datapath. It holds one instruction in an internal instruction register (IR), decodes it, and steps the datapath through register read, ALU, and write-back using a Moore FSM. A start/ready handshake (s/w) connects it to the upstream fetch/test logic. It also generates the sign-extended immediates the datapath consumes.

Parameters:
CNT_W, 16, width of the retired-instruction counter (optional feature only).

Ports:
clk  input  1  rising-edge clock, sole clock
reset_n  input  1  synchronous, active-low reset; sampled on rising clk
s  input  1  start request; sampled only in WAIT
load  input  1  IR load enable; effective only in WAIT
in  input  16  instruction word captured into IR
w  output  1  ready; 1 only in WAIT
err  output  1  sticky illegal-instruction flag
vsel  output  4  one-hot write-back source select (0001=C, 0100=sximm8)
loada, loadb, loadc, loads  output  1 each  datapath register enables
asel, bsel  output  1 each  ALU operand selects (asel=1 forces Ain=0)
shift  output  2  shifter op = IR[4:3]
ALUop  output  2  ALU op
readnum, writenum  output  3 each  register file addresses
write  output  1  register file write enable
sximm8  output  16  sign-extended IR[7:0]
sximm5  output  16  sign-extended IR[4:0]
instr_count  output  CNT_W  retired-instruction count (0 when feature absent)

Behaviour:
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Legal instructions: MOVI (110,10); MOV (110,00); ADD/CMP/AND/MVN (101, op 00/01/10/11). Everything else is illegal.
- Reset (reset_n=0 at an edge): state=WAIT, IR=0, err=0, instr_count=0. Reset wins over every other input. If reset arrives mid-instruction, the controller is in WAIT from the next edge on, and no write or load enable is asserted afterwards.
- All outputs are combinational from state and IR only (Moore). No input feeds an output combinationally.
- Idle values in any state that does not drive them: enables=0, vsel=0001, readnum=writenum=0, shift=00, ALUop=00, asel=bsel=0.
- WAIT: w=1.
  - load=1 captures in into IR.
  - s=1 moves to DECODE and clears err.
  - s and load in the same cycle is legal: DECODE uses the newly loaded IR.
  - load and s are ignored in all other states.
- DECODE:
  - MOVI goes to WRITE_IMM.
  - MOV and MVN go to GET_B.
  - ADD, CMP and AND go to GET_A.
  - Illegal sets err=1 and goes to WAIT (not counted as retired).
- WRITE_IMM: vsel=0100, writenum=Rn, write=1. Goes to WAIT.
- GET_A: readnum=Rn, loada=1. Goes to GET_B.
- GET_B: readnum=Rm, loadb=1. Goes to ALU.
- ALU: shift=sh, bsel=0.
  - MOV: asel=1, ALUop=00.
  - MVN: asel=1, ALUop=11.
  - Otherwise: asel=0, ALUop=op.
  - CMP: loads=1, loadc=0, then goes to WAIT.
  - Others: loadc=1, loads=0, then go to WRITE_REG.
- WRITE_REG: vsel=0001, writenum=Rd, write=1. Goes to WAIT.
- Latency, measured from the edge that samples s=1 to w=1:
  - MOVI: 3 cycles.
  - MOV, MVN, CMP: 5 cycles.
  - ADD, AND: 6 cycles.
  - Illegal: 2 cycles.
- Back-to-back operation: s held high restarts on the first WAIT cycle, so w is high for exactly one cycle.
- Exactly one of loada/loadb/loadc/loads/write is high in any non-WAIT, non-DECODE state.

Optional Feature:
- Macro: DATAPATH_CTRL_PERF_CNT_EN.
- Defined: instr_count increments by 1 on each edge leaving WRITE_IMM, WRITE_REG, or ALU with CMP. It wraps modulo 2^CNT_W and resets to 0.
- Undefined: instr_count is tied to 0 and no counter flops exist.

Test Plan:
- Reset, then in=16'hD105 (MOVI R1,#5), load=1, s=1 -> cycle +2: vsel=0100, writenum=1, write=1, sximm8=16'h0005; w=1 at +3.
- IR=16'hD2FE (MOVI R2,#-2) -> sximm8=16'hFFFE; IR=16'h0010 -> sximm5=16'hFFF0.
- IR=16'hA168 (ADD R3,R1,R0 LSL) -> GET_A readnum=1 loada; GET_B readnum=0 loadb; ALU shift=01 ALUop=00 loadc; WRITE_REG writenum=3 write; w=1 at +6.
- IR=16'hA901 (CMP R1,R1) -> ALU state loads=1, loadc=0, write never asserted; w=1 at +5.
- IR=16'hE000 (illegal) with s=1 -> err=1, w=1 at +2; next accepted s clears err. load=1 during busy leaves IR unchanged.
- reset_n=0 while in GET_B -> WAIT next cycle, write=0 thereafter, instr_count=0 (with macro: 3 retired instructions counted before reset).
